wb_arbiter: RTL
===============

# wb_arbiter

Register-file write-port arbiter and long-latency scoreboard. Shares the single register-file write port between the in-order WB stage and a multi-cycle long-latency unit (LLU, e.g. multiply/divide) that returns results out of pipeline order. Tracks destinations of in-flight LLU operations, reports read-after-write and write-after-write hazards to decode, and freezes the pipeline when the LLU has waited too long. Sits between WB/LLU outputs and the register file.

## Interface
- `DW`, 16, data width
- `AW`, 3, register address width (8 registers)
- `STARVE_MAX`, 4, LLU wait cycles before a forced steal (range 1..15)

- `clk` in 1, rising-edge clock
- `rst_n` in 1, synchronous, active-low reset
- `wb_we_i` in 1, WB stage write request (already opcode-qualified)
- `wb_addr_i` in AW, WB destination register
- `wb_data_i` in DW, WB write data
- `llu_valid_i` in 1, LLU result valid
- `llu_addr_i` in AW, LLU destination register
- `llu_data_i` in DW, LLU result
- `llu_ready_o` out 1, LLU result accepted this cycle
- `iss_valid_i` in 1, decode issues an LLU op this cycle
- `iss_addr_i` in AW, destination register of the issued op
- `rs_a_i`, `rs_b_i`, `rd_i` in AW each, decode query addresses
- `hazard_o` out 1, decode must stall
- `stall_o` out 1, freeze the whole pipeline (WB inputs held)
- `rf_we_o` out 1, register-file write enable
- `rf_waddr_o` out AW, register-file write address
- `rf_wdata_o` out DW, register-file write data

## Operation
- FSM states: NORMAL, STEAL. Reset state is NORMAL.
- NORMAL: if `wb_we_i` is high, grant WB. Else if `llu_valid_i` is high, grant LLU and set `llu_ready_o`=1. `llu_ready_o` is combinational and is 0 whenever WB is granted.
- Wait counter (4 bit): increments each cycle with `llu_valid_i` && !`llu_ready_o`. Clears on any LLU grant. When the counter reaches `STARVE_MAX` in NORMAL, go to STEAL next cycle.
- STEAL, one cycle only: `stall_o`=1 (registered, driven from the state), LLU is granted unconditionally, and `wb_we_i` is ignored. The pipeline holds WB, so the WB write re-presents next cycle. Return to NORMAL and clear the counter.
- If `llu_valid_i` drops while in STEAL, there is no grant; return to NORMAL.
- Scoreboard: 2^AW pending bits.
  - `iss_valid_i` sets `pending[iss_addr_i]`.
  - An LLU grant clears `pending[llu_addr_i]`.
  - Set and clear of the same address in the same cycle: set wins.
  - Setting an already-pending bit is idempotent.
- `hazard_o` = `pending[rs_a_i]` | `pending[rs_b_i]` | `pending[rd_i]`, combinational from the registered bits.
- A WB write to a pending register is not checked here. Decode prevents it via the `rd_i` query.
- Reset mid-operation clears all pending bits, the counter and the state. Any in-flight LLU result is discarded by the system reset.

## Timing
- All three `rf_*` outputs are registered: the grant in cycle N produces the write in cycle N+1. `rf_we_o` is 0 when nothing is granted.
- Reset values: `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, `stall_o`=0, `llu_ready_o`=0, `hazard_o`=0.
- Pending bits update at the clock edge. `hazard_o` reflects an issue from cycle N starting in cycle N+1.
- Maximum LLU wait: `STARVE_MAX`+1 cycles from `llu_valid_i` to `llu_ready_o`.

## Configuration
- `WB_ARB_FWD_EN` defined: `hazard_o` masks out the pending bit of `llu_addr_i` while that LLU result is granted in the current cycle. Decode may proceed because the register-file write lands before the dependent read (register file is write-before-read).
- `WB_ARB_FWD_EN` undefined: `hazard_o` uses only the registered pending bits, which costs one extra stall cycle per LLU dependency.

## Structure
- Package `wb_arb_pkg` holds:
  - the `DW`/`AW` defaults;
  - the FSM state enum `wb_arb_state_t` {NORMAL, STEAL};
  - the opcode constants that decode uses to classify LLU ops.
- Sub-module `wb_scoreboard`: pending bits, set/clear priority, three-port hazard lookup and the `WB_ARB_FWD_EN` mask.
- The top level holds the FSM, the wait counter, the grant mux and the output registers.

## Test plan
- WB only: `wb_we_i`=1, addr 3, data 0x1234 → next cycle `rf_we_o`=1, `rf_waddr_o`=3, `rf_wdata_o`=0x1234; `llu_ready_o`=0.
- LLU only: `llu_valid_i`=1, addr 5, data 0xBEEF, WB idle → `llu_ready_o`=1 the same cycle; next cycle reg 5 is written with 0xBEEF.
- Starvation (`STARVE_MAX`=4): WB writes every cycle with LLU valid → after 4 waiting cycles, `stall_o`=1 for exactly one cycle, LLU is written, and the held WB write follows in the next cycle.
- Scoreboard: issue to reg 2, then query `rs_a_i`=2 → `hazard_o`=1 from the next cycle until the LLU grant for reg 2. With `WB_ARB_FWD_EN` it clears in the grant cycle; without it, one cycle later.
- Simultaneous issue and completion to reg 6 → pending[6] stays 1.
- Reset asserted with pending bits set and FSM in STEAL → all outputs 0, FSM in NORMAL, `hazard_o`=0 for every query.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared widths, FSM state type and LLU opcode classification for the
// register-file write-port arbiter.
package wb_arb_pkg;

    localparam int WB_ARB_DW = 16;
    localparam int WB_ARB_AW = 3;

    typedef enum logic {
        NORMAL = 1'b0,
        STEAL  = 1'b1
    } wb_arb_state_t;

    // Decode treats register-register ops with the MULDIV funct7 as LLU ops
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    function automatic logic is_llu_op(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the WB stage, the LLU, decode and the register-file
// write port; the arbiter takes the slave side.
interface wb_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int DW = WB_ARB_DW,
    parameter int AW = WB_ARB_AW
) ();

    logic          wb_we_i;
    logic [AW-1:0] wb_addr_i;
    logic [DW-1:0] wb_data_i;

    logic          llu_valid_i;
    logic [AW-1:0] llu_addr_i;
    logic [DW-1:0] llu_data_i;
    logic          llu_ready_o;

    logic          iss_valid_i;
    logic [AW-1:0] iss_addr_i;
    logic [AW-1:0] rs_a_i;
    logic [AW-1:0] rs_b_i;
    logic [AW-1:0] rd_i;
    logic          hazard_o;
    logic          stall_o;

    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;

    modport slave (
        input  wb_we_i, wb_addr_i, wb_data_i,
        input  llu_valid_i, llu_addr_i, llu_data_i,
        output llu_ready_o,
        input  iss_valid_i, iss_addr_i, rs_a_i, rs_b_i, rd_i,
        output hazard_o, stall_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport master (
        output wb_we_i, wb_addr_i, wb_data_i,
        output llu_valid_i, llu_addr_i, llu_data_i,
        input  llu_ready_o,
        output iss_valid_i, iss_addr_i, rs_a_i, rs_b_i, rd_i,
        input  hazard_o, stall_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard for in-flight LLU ops with three-port hazard
// lookup. WB_ARB_FWD_EN hides the register whose LLU result is being written now.
module wb_scoreboard
    import wb_arb_pkg::*;
#(
    parameter int AW = WB_ARB_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_issValid,
    input  logic [AW-1:0] i_issAddr,
    input  logic          i_clrValid,
    input  logic [AW-1:0] i_clrAddr,
    input  logic [AW-1:0] i_rsA,
    input  logic [AW-1:0] i_rsB,
    input  logic [AW-1:0] i_rd,
    output logic          o_hazard
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_setMask;
    logic [NREG-1:0] w_clrMask;
    logic [NREG-1:0] w_visible;

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (i_issValid) w_setMask[i_issAddr] = 1'b1;
        if (i_clrValid) w_clrMask[i_clrAddr] = 1'b1;
    end

    // Set is applied after clear so a same-cycle issue to the completing register survives
    always_ff @(posedge clk) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clrMask) | w_setMask;
    end

`ifdef WB_ARB_FWD_EN
    assign w_visible = r_pending & ~w_clrMask;
`else
    assign w_visible = r_pending;
`endif

    assign o_hazard = w_visible[i_rsA] | w_visible[i_rsB] | w_visible[i_rd];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between WB and the long-latency unit, with
// starvation steal and LLU scoreboard. Optional macro: WB_ARB_FWD_EN.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int DW = WB_ARB_DW;
    localparam int AW = WB_ARB_AW;
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    wb_arb_state_t r_state;
    logic [3:0]    r_waitCnt;
    logic          r_stall;
    logic          r_rfWe;
    logic [AW-1:0] r_rfWaddr;
    logic [DW-1:0] r_rfWdata;

    logic w_wbGrant;
    logic w_lluGrant;
    logic w_starve;
    logic w_hazard;

    // WB normally has priority; in STEAL the LLU wins and WB is ignored
    always_comb begin
        w_wbGrant  = 1'b0;
        w_lluGrant = 1'b0;
        if (rst_n) begin
            if (r_state == STEAL)  w_lluGrant = bus.llu_valid_i;
            else if (bus.wb_we_i)  w_wbGrant  = 1'b1;
            else                   w_lluGrant = bus.llu_valid_i;
        end
    end

    assign w_starve = (r_state == NORMAL) && (r_waitCnt >= STARVE_LIMIT) && !w_lluGrant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= NORMAL;
            r_waitCnt <= '0;
            r_stall   <= 1'b0;
            r_rfWe    <= 1'b0;
            r_rfWaddr <= '0;
            r_rfWdata <= '0;
        end else begin
            r_rfWe <= w_wbGrant | w_lluGrant;
            if (w_lluGrant) begin
                r_rfWaddr <= bus.llu_addr_i;
                r_rfWdata <= bus.llu_data_i;
            end else if (w_wbGrant) begin
                r_rfWaddr <= bus.wb_addr_i;
                r_rfWdata <= bus.wb_data_i;
            end

            case (r_state)
                NORMAL: begin
                    if (w_starve) begin
                        r_state <= STEAL;
                        r_stall <= 1'b1;
                    end
                end
                STEAL: begin
                    r_state <= NORMAL;
                    r_stall <= 1'b0;
                end
                default: begin
                    r_state <= NORMAL;
                    r_stall <= 1'b0;
                end
            endcase

            if (w_lluGrant || r_state == STEAL)
                r_waitCnt <= '0;
            else if (bus.llu_valid_i && r_waitCnt != 4'hF)
                r_waitCnt <= r_waitCnt + 4'd1;
        end
    end

    wb_scoreboard #(.AW(AW)) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_issValid (bus.iss_valid_i),
        .i_issAddr  (bus.iss_addr_i),
        .i_clrValid (w_lluGrant),
        .i_clrAddr  (bus.llu_addr_i),
        .i_rsA      (bus.rs_a_i),
        .i_rsB      (bus.rs_b_i),
        .i_rd       (bus.rd_i),
        .o_hazard   (w_hazard)
    );

    assign bus.llu_ready_o = w_lluGrant;
    assign bus.hazard_o    = w_hazard;
    assign bus.stall_o     = r_stall;
    assign bus.rf_we_o     = r_rfWe;
    assign bus.rf_waddr_o  = r_rfWaddr;
    assign bus.rf_wdata_o  = r_rfWdata;

endmodule
